// File: rtl/lsu_pkg.sv
// Shared types and pure helpers for the load/store memory port.
// Size encodings, the tracking-stage record, and lane/extension helpers.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } lsu_size_e;

  typedef struct packed {
    logic      vld;
    logic      load;
    logic      err;
    logic [2:0] off;
    lsu_size_e size;
    logic      uns;
  } lsu_trk_t;

  // off is the lane offset zero-extended to 3 bits; doubles only exist on 64-bit ports.
  function automatic logic lsu_misaligned(input logic [1:0] size, input logic [2:0] off,
                                          input logic xlen64);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_H:    bad = off[0];
      SZ_W:    bad = |off[1:0];
      SZ_D:    bad = (|off) || !xlen64;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

  function automatic logic [7:0] lsu_wstrb(input logic [1:0] size, input logic [2:0] off);
    logic [7:0] m;
    case (size)
      SZ_B:    m = 8'h01;
      SZ_H:    m = 8'h03;
      SZ_W:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m << off;
  endfunction

  function automatic logic [63:0] lsu_extend(input logic [63:0] d, input lsu_size_e size,
                                             input logic uns);
    logic [63:0] r;
    case (size)
      SZ_B:    r = uns ? {56'b0, d[7:0]}  : {{56{d[7]}},  d[7:0]};
      SZ_H:    r = uns ? {48'b0, d[15:0]} : {{48{d[15]}}, d[15:0]};
      SZ_W:    r = uns ? {32'b0, d[31:0]} : {{32{d[31]}}, d[31:0]};
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_mem_port_if.sv
// Request, response and memory-side signals of the load/store port.
// slave = the port itself; master = the pipeline plus memory driving it.
interface lsu_mem_port_if #(
  parameter int XLEN = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [31:0]       req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic              resp_valid;
  logic              resp_ready;
  logic [XLEN-1:0]   resp_rdata;
  logic              resp_err;
  logic              mem_en;
  logic              mem_wr;
  logic [31:0]       mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN/8-1:0] mem_wstrb;
  logic [XLEN-1:0]   mem_rdata;

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, req_size, req_unsigned,
    input  resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_en, mem_wr, mem_addr, mem_wdata, mem_wstrb
  );

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, req_size, req_unsigned,
    output resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_en, mem_wr, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/lsu_resp_fifo.sv
// Shift-register response FIFO; head entry is a flop so dat is registered and 0 when empty.
// Push visible on dat the cycle after; push and pop in the same cycle both take effect when full.
module lsu_resp_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 33
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] dat,
  output logic         full,
  output logic         empty
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  ent [DEPTH];
  logic [W-1:0]  nxt [DEPTH];
  logic [CW-1:0] cnt;
  logic          do_pop;
  int            wr_idx;

  assign empty  = (cnt == '0);
  assign full   = (cnt == CW'(DEPTH));
  assign dat    = ent[0];
  assign do_pop = pop && !empty;

  // Slots at or above cnt are kept at zero, so shifting in from the top is safe.
  always_comb begin
    nxt    = ent;
    wr_idx = int'(cnt) - (do_pop ? 1 : 0);
    if (do_pop) begin
      for (int i = 0; i < DEPTH - 1; i++) nxt[i] = ent[i+1];
      nxt[DEPTH-1] = '0;
    end
    if (push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i == wr_idx) nxt[i] = push_dat;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
    end else begin
      ent <= nxt;
      case ({push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: rtl/lsu_mem_port.sv
// Load/store port from MEM stage to a pipelined data memory; response LAT+1 cycles after accept.
// req_ready drops once DEPTH accesses are outstanding; responses hold while resp_ready is low.
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int LAT   = 1,
  parameter int DEPTH = 2
) (
  input logic           clock,
  input logic           reset,
  lsu_mem_port_if.slave bus
);
  localparam int OFFW = (XLEN == 64) ? 3 : 2;
  localparam int SW   = XLEN / 8;
  localparam int CW   = $clog2(DEPTH + 1);

  logic [OFFW-1:0] off;
  logic [2:0]      off3;
  logic            illegal;
  logic            accept;
  logic            pop;
  logic [CW-1:0]   outstanding;
  lsu_trk_t        trk_in;
  lsu_trk_t        trk [LAT];
  lsu_trk_t        tf;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] ext;
  logic            fifo_push;
  logic [XLEN:0]   fifo_din;
  logic [XLEN:0]   fifo_dat;
  logic            fifo_full;
  logic            fifo_empty;

  assign off     = bus.req_addr[OFFW-1:0];
  assign off3    = 3'(off);
  assign illegal = lsu_misaligned(bus.req_size, off3, XLEN == 64);
  assign accept  = bus.req_valid && bus.req_ready;

  assign bus.req_ready = reset && (outstanding < CW'(DEPTH));
  assign bus.mem_en    = accept && !illegal;
  assign bus.mem_wr    = bus.mem_en && bus.req_wr;
  assign bus.mem_addr  = {bus.req_addr[31:OFFW], {OFFW{1'b0}}};
  assign bus.mem_wdata = bus.req_wdata << {off, 3'b000};
  assign bus.mem_wstrb = bus.mem_wr ? SW'(lsu_wstrb(bus.req_size, off3)) : '0;

  always_comb begin
    trk_in = '0;
    if (accept) begin
      trk_in.vld  = 1'b1;
      trk_in.load = !bus.req_wr;
      trk_in.err  = illegal;
      trk_in.off  = off3;
      trk_in.size = lsu_size_e'(bus.req_size);
      trk_in.uns  = bus.req_unsigned;
    end
  end

  // Tracking pipeline matches memory read latency so mem_rdata lines up with the last stage.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LAT; i++) trk[i] <= '0;
    end else begin
      trk[0] <= trk_in;
      for (int i = 1; i < LAT; i++) trk[i] <= trk[i-1];
    end
  end

  assign tf        = trk[LAT-1];
  assign shifted   = bus.mem_rdata >> {tf.off, 3'b000};
  assign ext       = XLEN'(lsu_extend(64'(shifted), tf.size, tf.uns));
  assign fifo_din  = {tf.err, (tf.load && !tf.err) ? ext : {XLEN{1'b0}}};
  assign fifo_push = tf.vld && (!fifo_full || pop);

  assign pop            = bus.resp_valid && bus.resp_ready;
  assign bus.resp_valid = !fifo_empty;
  assign bus.resp_err   = fifo_dat[XLEN];
  assign bus.resp_rdata = fifo_dat[XLEN-1:0];

  lsu_resp_fifo #(
    .DEPTH (DEPTH),
    .W     (XLEN + 1)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (fifo_push),
    .push_dat (fifo_din),
    .pop      (pop),
    .dat      (fifo_dat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Covers both in-flight stages and queued responses, bounding FIFO occupancy.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      outstanding <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end
endmodule
